// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: gray/binary pointer conversions and the read-side occupancy type.
// Used by both the read-side and write-side controllers.
package fifo_pkg;

  // Widest pointer the conversions handle; narrower pointers are zero-extended in and truncated out.
  localparam int PTR_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr.sv
// Binary + gray pointer counter with synchronous active-low reset.
// The gray output is registered directly from the next binary value, so it stays glitch-free for CDC.
module gray_ptr
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  logic [W-1:0] bin_nxt;

  assign bin_nxt = bin + W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin  <= '0;
      gray <= '0;
    end else if (inc) begin
      bin  <= bin_nxt;
      gray <= W'(bin2gray(PTR_W'(bin_nxt)));
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain controller: read pointer, empty detect, and a 2-entry FWFT output buffer.
// Optional macro FIFO_RD_LEVEL_EN adds the registered rd_level output (words still in memory).
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr_sync,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_W:0]   rd_level
`endif
);

  localparam int PTR_N = ADDR_W + 1;

  logic [ADDR_W:0]   rptr_bin;
  occ_t              occ;
  logic              inflight;
  logic              pop;
  logic [1:0]        lvl;
  logic [DATA_W-1:0] tail_q;
  logic [DATA_W-1:0] head_nxt;
  logic [DATA_W-1:0] tail_nxt;

  gray_ptr #(.W(PTR_N)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (mem_ren),
    .bin  (rptr_bin),
    .gray (rptr_gray)
  );

  // Output stream: a word transfers on a cycle where dout_valid && dout_ready; dout_ready is
  // don't-care while dout_valid is low, and dout/dout_valid hold while the consumer stalls.
  assign pop = dout_valid && dout_ready;

  // Buffered + in-flight words after this edge; invariant keeps it at most 2.
  assign lvl = 2'(occ) + {1'b0, inflight} - {1'b0, pop};

  assign empty     = (rptr_gray == wptr_sync);
  assign mem_ren   = rst && !empty && (lvl < 2'd2);
  assign mem_raddr = rptr_bin[ADDR_W-1:0];

  // Capture lands in the first free slot after any pop has shifted the tail to the head.
  always_comb begin
    head_nxt = dout;
    tail_nxt = tail_q;
    if (pop) begin
      head_nxt = tail_q;
    end
    if (inflight) begin
      if (occ == OCC_EMPTY || (occ == OCC_ONE && pop)) begin
        head_nxt = mem_rdata;
      end else begin
        tail_nxt = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ        <= OCC_EMPTY;
      inflight   <= 1'b0;
      dout       <= '0;
      tail_q     <= '0;
      dout_valid <= 1'b0;
    end else begin
      occ        <= occ_t'(lvl);
      inflight   <= mem_ren;
      dout       <= head_nxt;
      tail_q     <= tail_nxt;
      dout_valid <= (lvl != 2'd0);
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_W:0] wptr_bin;

  assign wptr_bin = PTR_N'(gray2bin(PTR_W'(wptr_sync)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_level <= '0;
    end else begin
      rd_level <= wptr_bin - rptr_bin;
    end
  end
`else
  logic rptr_msb_unused;
  assign rptr_msb_unused = rptr_bin[ADDR_W];
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-domain controller for the async FIFO. It owns the read pointer (binary and gray) and detects empty by comparing against the write gray pointer already brought across by the 2-flop `sync` block. It sequences reads from the registered-output dual-port memory and presents a first-word-fall-through valid/ready stream through a 2-entry output buffer. Its `rptr_gray` output feeds the `sync` instance that crosses into the write domain.

Parameters:
- ADDR_W, 3, memory address width; pointers are ADDR_W+1 bits wide (4 bits by default).
- DATA_W, 8, data word width.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- wptr_sync  in  ADDR_W+1  write pointer, gray-coded, already synchronized into this domain.
- rptr_gray  out  ADDR_W+1  registered gray read pointer, sent to the write domain via `sync`.
- mem_ren  out  1  memory read enable.
- mem_raddr  out  ADDR_W  memory read address; equals rptr_bin[ADDR_W-1:0].
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_ren is high.
- dout  out  DATA_W  head-of-stream data.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts the word.
- empty  out  1  raw empty: rptr_gray == wptr_sync.

Behaviour:
- Reset (rst low at a clk edge) sets:
  - rptr_bin, rptr_gray = 0;
  - occupancy occ = 0; inflight = 0;
  - dout = 0; dout_valid = 0.
  - mem_ren is forced 0 while rst is low.
- State: occ in {0,1,2} (buffered words) plus inflight (registered copy of mem_ren). The FSM is the occ counter: EMPTY, ONE, FULL.
- pop = dout_valid && dout_ready. dout_ready is ignored while dout_valid = 0.
- Issue: mem_ren = rst && !empty && (occ + inflight - pop) < 2. This is combinational from registered state and the registered wptr_sync.
- On mem_ren:
  - rptr_bin increments modulo 2^(ADDR_W+1);
  - rptr_gray <= bin2gray(rptr_bin+1) on the same edge.
- Capture: when inflight = 1, mem_rdata is written into the buffer tail at the end of that cycle.
- Latency: first word has mem_ren in cycle N, capture at end of N+1, dout_valid = 1 in cycle N+2.
- Sustained throughput is 1 word/cycle with dout_ready held high.
- Simultaneous capture and pop: occ is unchanged; the old tail shifts to the head.
- Buffer ordering is strict FIFO. dout is the head entry, registered.
- dout and dout_valid stay stable while dout_valid && !dout_ready.
- Empty boundary: full-width gray equality. A wrap of the extra MSB is handled naturally by the gray compare; no reads are issued while empty.
- Full is never detected here; that is the write-side responsibility.
- Reset mid-operation: buffered and in-flight data are discarded. Any mem_rdata arriving in the following cycle is ignored. The write side must be reset in the same window.

Optional Feature:
- Macro FIFO_RD_LEVEL_EN.
- When defined: adds output port `rd_level` (ADDR_W+1 bits), registered.
  - rd_level = gray2bin(wptr_sync) - rptr_bin, modulo 2^(ADDR_W+1).
  - It counts words still in memory, excluding buffered and in-flight words. Reset value is 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package `fifo_pkg`:
  - functions bin2gray and gray2bin, parameterized by width via a localparam PTR_W;
  - typedef occ_t (2-bit).
- The package is shared with the write-side controller.
- Sub-module `gray_ptr`: binary+gray counter with inc input, sync active-low reset, and outputs bin and gray. It is reused by the write side.

Test Plan:
1. rst=0 for 2 cycles → rptr_gray=0000, mem_ren=0, dout_valid=0, empty=1.
2. wptr_sync=0001, dout_ready=1, mem_rdata=8'hA5 → mem_ren=1 with mem_raddr=0 in cycle 0; rptr_gray=0001 and empty=1 in cycle 1; dout=A5, dout_valid=1 in cycle 2; dout_valid=0 in cycle 3.
3. wptr_sync=0110 (4 words), dout_ready=0 → exactly 2 reads issued, then mem_ren=0; dout holds word 0. Raise dout_ready → words 0,1,2,3 on consecutive cycles, then dout_valid=0.
4. Stream 20 words with ADDR_W=3 → rptr_gray passes 1000 (bin 15) and wraps to 0000; data order is exact, with no duplicated or dropped words.
5. Mid-stream with occ=2 and inflight=1, rst=0 for 1 cycle → next cycle dout_valid=0 and rptr_gray=0000; the late mem_rdata is not captured.
6. FIFO_RD_LEVEL_EN, wptr_sync=0111 (5), dout_ready=0 → after 2 reads rd_level=3.
